// File: rtl/stat_display_ctrl_pkg.sv
// stat_display_ctrl_pkg: shared source indices, mode encoding and hex glyphs
// for the performance-counter display scheduler.
package stat_display_ctrl_pkg;
    localparam int NUM_SRC = 5;
    localparam logic [2:0] SRC_TOTAL   = 3'd0;
    localparam logic [2:0] SRC_COND    = 3'd1;
    localparam logic [2:0] SRC_UNCOND  = 3'd2;
    localparam logic [2:0] SRC_COND_OK = 3'd3;
    localparam logic [2:0] SRC_LU      = 3'd4;
    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_t;
    // active-low {g,f,e,d,c,b,a} glyphs for 0..F
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/stat_display_ctrl_hex7seg.sv
// hex7seg: combinational 4-bit to active-low 7-segment decoder.
module hex7seg
    import stat_display_ctrl_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = HEX_GLYPH[nib];
endmodule

// File: rtl/stat_display_ctrl.sv
// stat_display_ctrl: shares one 8-digit seven-segment display among five
// performance counters, with auto/manual source select and halt snapshot.
module stat_display_ctrl
    import stat_display_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int ROT_TICKS = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [31:0] total,
    input  logic [31:0] conditional,
    input  logic [31:0] unconditional,
    input  logic [31:0] conditional_success,
    input  logic [31:0] lu_times,
    input  logic        btn_next,
    input  logic        auto_en,
    output logic [2:0]  sel,
    output logic        frozen,
    output logic [31:0] disp_val,
    output logic [7:0]  an,
    output logic [7:0]  seg
);
    localparam int RW = $clog2(ROT_TICKS);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [RW-1:0] ROT_LAST  = RW'(ROT_TICKS - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    mode_t         mode, mode_nxt;
    logic          halt_q, btn_q, halt_armed;
    logic          halt_rise, btn_rise, rot_exp, advance;
    logic [RW-1:0] rot_cnt;
    logic [SW-1:0] scan_cnt;
    logic [2:0]    digit;
    logic [6:0]    glyph;
    logic [31:0]   live [NUM_SRC];
    logic [31:0]   snap [NUM_SRC];

    assign live[SRC_TOTAL]   = total;
    assign live[SRC_COND]    = conditional;
    assign live[SRC_UNCOND]  = unconditional;
    assign live[SRC_COND_OK] = conditional_success;
    assign live[SRC_LU]      = lu_times;

    // halt_armed blocks a halt held through reset from re-snapshotting
    // until halt has been seen low at least once.
    assign halt_rise = halt & ~halt_q & halt_armed;
    assign btn_rise  = btn_next & ~btn_q;

    always_ff @(posedge clk) begin
        if (rst) mode <= MODE_MANUAL;
        else     mode <= mode_nxt;
    end

    always_comb begin
        mode_nxt = auto_en ? MODE_AUTO : MODE_MANUAL;
        rot_exp  = (mode == MODE_AUTO) && (rot_cnt == ROT_LAST);
        advance  = btn_rise | rot_exp;
    end

    hex7seg u_hex (
        .nib (disp_val[{digit, 2'b00} +: 4]),
        .seg (glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q     <= 1'b0;
            btn_q      <= 1'b0;
            halt_armed <= 1'b0;
            rot_cnt    <= '0;
            sel        <= SRC_TOTAL;
            snap       <= '{default: '0};
            frozen     <= 1'b0;
            disp_val   <= '0;
            scan_cnt   <= '0;
            digit      <= '0;
            an         <= 8'hFF;
            seg        <= 8'hFF;
        end else begin
            halt_q     <= halt;
            btn_q      <= btn_next;
            halt_armed <= halt_armed | ~halt;
            rot_cnt    <= (mode == MODE_MANUAL || advance) ? '0 : rot_cnt + RW'(1);
            if (advance) sel <= (sel == SRC_LU) ? SRC_TOTAL : sel + 3'd1;
            if (halt_rise) snap <= live;
            frozen     <= halt & (frozen | halt_rise);
            disp_val   <= frozen ? snap[sel] : live[sel];
            scan_cnt   <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SW'(1);
            if (scan_cnt == SCAN_LAST) digit <= digit + 3'd1;
            an         <= ~(8'b1 << digit);
            seg        <= {~(digit == 3'd0 && frozen), glyph};
        end
    end
endmodule
